// File: rtl/pos_decoder_pkg.sv
// Shared constants and entry type for the position-code decoder.
// Optional range checking is enabled by defining POS_DECODER_RANGE_CHECK_EN.
package pos_decoder_pkg;

  localparam int POS_W     = 6;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] mask;
    logic                 err;
  } entry_t;

endpackage

// File: rtl/pos_decoder_pos_to_onehot.sv
// Combinational position-code to one-hot decoder with an out-of-range flag.
module pos_to_onehot
  import pos_decoder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [POS_W-1:0] in_pos,
  output logic [WIDTH-1:0] mask,
  output logic             oor
);

  // Code k in 1..WIDTH selects bit k-1; zero and out-of-range codes give no bit.
  always_comb begin
    mask = '0;
    oor  = (32'(in_pos) > 32'(WIDTH));
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (32'(in_pos) == 32'(i + 1));
    end
  end

endmodule

// File: rtl/pos_decoder.sv
// Position-code decoder feeding a DEPTH-entry FIFO with valid/ready handshakes.
// Define POS_DECODER_RANGE_CHECK_EN to flag out-of-range codes on out_err.
module pos_decoder
  import pos_decoder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] dec_mask_s;
  logic             dec_oor_s;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mask_mem_q [DEPTH];
  logic [WIDTH-1:0] mask_mem_d [DEPTH];
  logic             push_s, pop_s;

  pos_to_onehot #(.WIDTH(WIDTH)) u_dec (
    .in_pos (in_pos),
    .mask   (dec_mask_s),
    .oor    (dec_oor_s)
  );

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = 2'(count_q);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Pointer, occupancy and storage next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mask_mem_d = mask_mem_q;
    if (push_s) begin
      wr_ptr_d             = wr_ptr_q + AW'(1);
      mask_mem_d[wr_ptr_q] = dec_mask_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mask_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mask_mem_q <= mask_mem_d;
    end
  end

  // Head mask is forced to zero whenever the buffer is empty.
  always_comb begin
    if (out_valid) begin
      out_mask = mask_mem_q[rd_ptr_q];
    end else begin
      out_mask = '0;
    end
  end

`ifdef POS_DECODER_RANGE_CHECK_EN
  logic [DEPTH-1:0] err_mem_q, err_mem_d;

  // Error bit storage alongside the masks.
  always_comb begin
    err_mem_d = err_mem_q;
    if (push_s) begin
      err_mem_d[wr_ptr_q] = dec_oor_s;
    end else begin
      err_mem_d = err_mem_q;
    end
  end

  // Error bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mem_q <= '0;
    end else begin
      err_mem_q <= err_mem_d;
    end
  end

  // Head error flag, zero when empty.
  always_comb begin
    if (out_valid) begin
      out_err = err_mem_q[rd_ptr_q];
    end else begin
      out_err = 1'b0;
    end
  end
`else
  logic unused_oor_s;
  assign unused_oor_s = dec_oor_s;
  assign out_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pos_decoder.sv
// Self-checking bench for pos_decoder: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_pos_decoder;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [5:0]        in_pos;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out_mask;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [WIDTH:0] model_q [$];   // {err, mask}

  pos_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pos    (in_pos),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_mask  (out_mask),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_entry(input int k);
    logic [63:0] m;
    logic        e;
    m = (k >= 1 && k <= WIDTH) ? (64'd1 << (k - 1)) : 64'd0;
`ifdef POS_DECODER_RANGE_CHECK_EN
    e = (k > WIDTH);
`else
    e = 1'b0;
`endif
    return {e, m[WIDTH-1:0]};
  endfunction

  task automatic check_outputs(input string tag);
    logic [WIDTH:0] head;
    head = (model_q.size() != 0) ? model_q[0] : '0;
    chk({tag, ".count"},     64'(count),     64'(model_q.size()));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(model_q.size() < DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    chk({tag, ".out_mask"},  64'(out_mask),  64'(head[WIDTH-1:0]));
    chk({tag, ".out_err"},   64'(out_err),   64'(head[WIDTH]));
  endtask

  // One cycle: drive, check current outputs, clock, then advance the model.
  task automatic step(input string tag, input logic iv, input int pos, input logic ordy);
    bit do_push, do_pop;
    in_valid  = iv;
    in_pos    = 6'(pos);
    out_ready = ordy;
    #1;
    check_outputs(tag);
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() != 0);
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(ref_entry(pos));
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_pos = 6'd0; out_ready = 1'b0;
    #2;
    check_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First push right after reset, delivered next cycle, then drained.
    step("first_push", 1'b1, 1, 1'b1);
    chk("first_mask", 64'(out_mask), 64'h1);
    step("first_head", 1'b0, 0, 1'b1);
    step("first_empty", 1'b0, 0, 1'b1);

    // Sweep every legal code with the consumer always ready.
    for (int k = 0; k <= 32; k++) step("sweep", 1'b1, k, 1'b1);
    for (int k = 0; k < 3; k++) step("sweep_drain", 1'b0, 0, 1'b1);

    // Fill with 6 and 33, third push must be ignored.
    step("fill6", 1'b1, 6, 1'b0);
    step("fill33", 1'b1, 33, 1'b0);
    step("full_ignore", 1'b1, 5, 1'b0);
    chk("full_count", 64'(count), 64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step("drain_a", 1'b0, 0, 1'b1);
    step("drain_b", 1'b0, 0, 1'b1);
    step("drain_c", 1'b0, 0, 1'b1);

    // Simultaneous push and pop at count=1.
    step("one_load", 1'b1, 3, 1'b0);
    step("pushpop", 1'b1, 32, 1'b1);
    chk("pushpop_count", 64'(count), 64'd1);
    chk("pushpop_head", 64'(out_mask), 64'h80000000);
    step("pushpop_drain", 1'b0, 0, 1'b1);

    // Full buffer: push and pop requested together, only pop happens.
    step("f_a", 1'b1, 10, 1'b0);
    step("f_b", 1'b1, 20, 1'b0);
    step("full_pop_only", 1'b1, 7, 1'b1);
    chk("after_full_pop_in_ready", 64'(in_ready), 64'd1);
    chk("after_full_pop_count", 64'(count), 64'd1);
    step("f_drain", 1'b0, 0, 1'b1);

    // Stall with a full buffer, then asynchronous reset mid-cycle.
    step("h_a", 1'b1, 17, 1'b0);
    step("h_b", 1'b1, 2, 1'b0);
    held = out_mask;
    for (int c = 0; c < 5; c++) begin
      step("hold", 1'b0, 0, 1'b0);
      chk("hold_stable", 64'(out_mask), 64'(held));
    end
    chk("hold_value", 64'(held), 64'h10000);
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_mask", 64'(out_mask), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_reset_push", 1'b1, 9, 1'b0);
    chk("post_reset_mask", 64'(out_mask), 64'h100);
    step("post_reset_drain", 1'b0, 0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
